// File: rtl/kulisch_to_fp16_if.sv
// kulisch_to_fp16_if
// Groups the valid/ready handshakes and result signals of the Kulisch-to-fp16
// converter.
//   i_valid / o_ready / i_kulisch_acc          : upstream side (accumulator word)
//   o_valid / i_ready / o_fp_data / o_overflow /
//   o_underflow / o_inexact                    : downstream side (fp16 result + flags)
// Modports:
//   master : producer/consumer environment that drives the block
//   slave  : the converter itself
interface kulisch_to_fp16_if #(
    parameter int unsigned AWIDTH = 91,
    parameter int unsigned DWIDTH = 16
) ();
    logic              i_valid;
    logic              o_ready;
    logic [AWIDTH-1:0] i_kulisch_acc;
    logic              o_valid;
    logic              i_ready;
    logic [DWIDTH-1:0] o_fp_data;
    logic              o_overflow;
    logic              o_underflow;
    logic              o_inexact;

    modport master (
        output i_valid, i_kulisch_acc, i_ready,
        input  o_ready, o_valid, o_fp_data, o_overflow, o_underflow, o_inexact
    );

    modport slave (
        input  i_valid, i_kulisch_acc, i_ready,
        output o_ready, o_valid, o_fp_data, o_overflow, o_underflow, o_inexact
    );
endinterface

// File: rtl/kulisch_to_fp16.sv
// kulisch_to_fp16
// Converts a two's-complement Kulisch accumulator word (value = acc * 2^-FWIDTH)
// to IEEE-754 binary16 with round-to-nearest-even and overflow/underflow/inexact
// flags. Three-stage pipeline with valid/ready on both sides:
//   stage 1: sign / magnitude
//   stage 2: leading-one detect, mantissa/guard/sticky extraction
//   stage 3: round and pack into registered outputs
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : kulisch_to_fp16_if.slave (input word handshake, result handshake, flags)
module kulisch_to_fp16 #(
    parameter int unsigned AWIDTH = 91,
    parameter int unsigned FWIDTH = 48,
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned EWIDTH = 5,
    parameter int unsigned MWIDTH = 10,
    parameter int unsigned BIAS   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    kulisch_to_fp16_if.slave   bus_io
);
    localparam int unsigned PW       = $clog2(AWIDTH);
    // Leading-one position of the smallest normal (e = 1-BIAS) and the largest normal.
    localparam int unsigned MinNormP = FWIDTH - BIAS + 1;
    localparam int unsigned MaxNormP = FWIDTH + BIAS;
    // Bit of mag that carries the subnormal LSB weight 2^(1-BIAS-MWIDTH).
    localparam int unsigned SubLsb   = MinNormP - MWIDTH;
    localparam int unsigned RW       = EWIDTH + MWIDTH;

    logic en;

    // Stage 1 state
    logic              s1_valid_q;
    logic              s1_sign_q;
    logic [AWIDTH-1:0] s1_mag_q;
    logic [AWIDTH-1:0] s1_mag_d;

    // Stage 2 state
    logic              s2_valid_q;
    logic              s2_sign_q;
    logic              s2_nz_q,     s2_nz_d;
    logic              s2_ovf_q,    s2_ovf_d;
    logic [EWIDTH-1:0] s2_exp_q,    s2_exp_d;
    logic [MWIDTH-1:0] s2_mant_q,   s2_mant_d;
    logic              s2_guard_q,  s2_guard_d;
    logic              s2_sticky_q, s2_sticky_d;

    // Output (stage 3) state
    logic              out_valid_q;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_ovf_q,  out_ovf_d;
    logic              out_udf_q,  out_udf_d;
    logic              out_nx_q,   out_nx_d;

    logic [PW-1:0]     lead_pos;
    logic [AWIDTH-2:0] norm_bits;
    logic              round_up;
    logic [RW-1:0]     rounded;

    // The whole pipeline moves together; it only stalls when a result is
    // waiting and downstream refuses it.
    assign en = !out_valid_q || bus_io.i_ready;

    assign bus_io.o_ready     = en;
    assign bus_io.o_valid     = out_valid_q;
    assign bus_io.o_fp_data   = out_data_q;
    assign bus_io.o_overflow  = out_ovf_q;
    assign bus_io.o_underflow = out_udf_q;
    assign bus_io.o_inexact   = out_nx_q;

    // Stage 1: magnitude. -2^(AWIDTH-1) negates to itself, which read as
    // unsigned is exactly 2^(AWIDTH-1), so no wrap handling is needed.
    always_comb begin
        s1_mag_d = bus_io.i_kulisch_acc;
        if (bus_io.i_kulisch_acc[AWIDTH-1]) begin
            s1_mag_d = (~bus_io.i_kulisch_acc) + AWIDTH'(1);
        end
    end

    // Stage 2: normalise.
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < AWIDTH; i++) begin
            if (s1_mag_q[i]) lead_pos = PW'(i);
        end
        s2_nz_d  = |s1_mag_q;
        // Left-align the leading one to the (dropped) MSB; what remains is the
        // fraction field followed by guard and sticky bits, zero-filled below.
        norm_bits = (AWIDTH-1)'(s1_mag_q << (PW'(AWIDTH - 1) - lead_pos));
        s2_ovf_d  = s2_nz_d && (int'(lead_pos) > int'(MaxNormP));
        if (int'(lead_pos) >= int'(MinNormP)) begin
            s2_exp_d    = EWIDTH'(int'(lead_pos) - int'(MinNormP) + 1);
            s2_mant_d   = norm_bits[AWIDTH-2 -: MWIDTH];
            s2_guard_d  = norm_bits[AWIDTH-2-MWIDTH];
            s2_sticky_d = |norm_bits[AWIDTH-3-MWIDTH:0];
        end else begin
            // Subnormal (and zero): fixed window, exponent field 0.
            s2_exp_d    = '0;
            s2_mant_d   = s1_mag_q[SubLsb +: MWIDTH];
            s2_guard_d  = s1_mag_q[SubLsb-1];
            s2_sticky_d = |s1_mag_q[SubLsb-2:0];
        end
    end

    // Stage 3: round to nearest even and pack. Rounding on the joined
    // {exp, mant} field lets a mantissa carry bump the exponent, including the
    // subnormal-to-smallest-normal case.
    always_comb begin
        round_up   = s2_guard_q && (s2_sticky_q || s2_mant_q[0]);
        rounded    = {s2_exp_q, s2_mant_q} + RW'(round_up);
        out_ovf_d  = s2_nz_q && (s2_ovf_q || (rounded[RW-1:MWIDTH] == '1));
        out_nx_d   = s2_nz_q && (s2_guard_q || s2_sticky_q || out_ovf_d);
        out_udf_d  = s2_nz_q && (s2_exp_q == '0) && (s2_guard_q || s2_sticky_q);
        out_data_d = {s2_sign_q, rounded};
        if (!s2_nz_q) begin
            out_data_d = '0;
        end else if (out_ovf_d) begin
            out_data_d = {s2_sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_nz_q     <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_exp_q    <= '0;
            s2_mant_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_udf_q   <= 1'b0;
            out_nx_q    <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= bus_io.i_valid;
            s1_sign_q   <= bus_io.i_kulisch_acc[AWIDTH-1];
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_nz_q     <= s2_nz_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_exp_q    <= s2_exp_d;
            s2_mant_q   <= s2_mant_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_udf_q   <= out_udf_d;
            out_nx_q    <= out_nx_d;
        end
    end
endmodule

// File: tb/tb_kulisch_to_fp16.sv
// tb_kulisch_to_fp16
// Directed-vector bench for kulisch_to_fp16: single-shot conversions with
// hand-computed fp16 results and flags, a backpressure stream, and a
// mid-stream reset. Results are packed as {fp16, ovf, udf, nx}.
module tb_kulisch_to_fp16;
    localparam int unsigned AW = 91;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kulisch_to_fp16_if #(.AWIDTH(AW), .DWIDTH(16)) bus ();

    kulisch_to_fp16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] acc_tab [6];
    logic [31:0]   exp_tab [6];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [15:0] d, input logic [2:0] f);
        return {13'b0, d, f};
    endfunction

    function automatic logic [31:0] res();
        return {13'b0, bus.o_fp_data, bus.o_overflow, bus.o_underflow, bus.o_inexact};
    endfunction

    // Send one word with downstream ready, check acceptance, latency and result.
    task automatic run_vec(input string tag, input logic [AW-1:0] acc,
                           input logic [15:0] ed, input logic [2:0] ef);
        int n;
        bus.i_ready       = 1'b1;
        bus.i_valid       = 1'b1;
        bus.i_kulisch_acc = acc;
        #1;
        check_eq({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd3);
        check_eq(tag, res(), pk(ed, ef));
    endtask

    initial begin
        int sent;
        int rcvd;
        logic [31:0] held;
        logic stalled;

        acc_tab[0] = 91'd1 << 48;          exp_tab[0] = pk(16'h3C00, 3'b000);
        acc_tab[1] = -(91'd3 << 47);       exp_tab[1] = pk(16'hBE00, 3'b000);
        acc_tab[2] = 91'd65504 << 48;      exp_tab[2] = pk(16'h7BFF, 3'b000);
        acc_tab[3] = 91'd1 << 24;          exp_tab[3] = pk(16'h0001, 3'b000);
        acc_tab[4] = 91'd3 << 23;          exp_tab[4] = pk(16'h0002, 3'b011);
        acc_tab[5] = 91'd4095 << 37;       exp_tab[5] = pk(16'h4000, 3'b001);

        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_kulisch_acc = '0;

        // Reset state
        #12;
        check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst_out", res(), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ordy", 32'(bus.o_ready), 32'd1);

        // Directed conversions
        run_vec("one",        91'd1 << 48,                   16'h3C00, 3'b000);
        run_vec("neg1p5",     -(91'd3 << 47),                16'hBE00, 3'b000);
        run_vec("max",        91'd65504 << 48,               16'h7BFF, 3'b000);
        run_vec("ovf_rnd",    91'd65520 << 48,               16'h7C00, 3'b101);
        run_vec("ovf_exp",    91'd1 << 64,                   16'h7C00, 3'b101);
        run_vec("ovf_neg",    -(91'd1 << 90),                16'hFC00, 3'b101);
        run_vec("min_norm",   91'd1 << 34,                   16'h0400, 3'b000);
        run_vec("sub_min",    91'd1 << 24,                   16'h0001, 3'b000);
        run_vec("sub_tie",    91'd1 << 23,                   16'h0000, 3'b011);
        run_vec("sub_rnd",    91'd3 << 23,                   16'h0002, 3'b011);
        run_vec("sub_carry",  (91'd1023 << 24) | (91'd1 << 23), 16'h0400, 3'b011);
        run_vec("tie_even",   (91'd1 << 48) | (91'd1 << 37), 16'h3C00, 3'b001);
        run_vec("tie_odd",    (91'd1 << 48) | (91'd3 << 37), 16'h3C02, 3'b001);
        run_vec("carry",      91'd4095 << 37,                16'h4000, 3'b001);
        run_vec("zero",       '0,                            16'h0000, 3'b000);

        // Drain the last result
        @(posedge clk); #1;
        check_eq("drain", 32'(bus.o_valid), 32'd0);

        // Backpressure stream: i_ready low in cycles 2..8
        sent = 0;
        rcvd = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
            bus.i_ready       = !(cyc >= 2 && cyc <= 8);
            bus.i_valid       = (sent < 6);
            bus.i_kulisch_acc = (sent < 6) ? acc_tab[sent] : '0;
            #1;
            check_eq($sformatf("bp_ordy_c%0d", cyc), 32'(bus.o_ready),
                     32'(!(cyc >= 3 && cyc <= 8)));
            if (stalled) begin
                check_eq("bp_hold_vld", 32'(bus.o_valid), 32'd1);
                check_eq("bp_hold", res(), held);
            end
            if (bus.o_valid && bus.i_ready) begin
                if (rcvd < 6) check_eq($sformatf("bp_data%0d", rcvd), res(), exp_tab[rcvd]);
                rcvd++;
            end
            stalled = bus.o_valid && !bus.i_ready;
            held    = res();
            if (bus.i_valid && bus.o_ready) sent++;
            @(posedge clk); #1;
        end
        check_eq("bp_sent", 32'(sent), 32'd6);
        check_eq("bp_rcvd", 32'(rcvd), 32'd6);
        bus.i_valid = 1'b0;
        #1;
        check_eq("bp_nodup", 32'(bus.o_valid), 32'd0);

        // Mid-stream reset with three words in flight
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_valid       = 1'b1;
            bus.i_kulisch_acc = acc_tab[k + 1];
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        #1;
        check_eq("pre_rst_vld", 32'(bus.o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", 32'(bus.o_valid), 32'd0);
        check_eq("mid_rst_out", res(), 32'd0);
        @(posedge clk); #1;
        check_eq("mid_rst_hold", 32'(bus.o_valid), 32'd0);
        #2 rst_n = 1'b1;
        #1;
        check_eq("post_rst_ordy", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("post_rst_flush", 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("post_rst_flush2", 32'(bus.o_valid), 32'd0);
        run_vec("post_rst", 91'd65504 << 48, 16'h7BFF, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
